// File: rtl/gsim_pkg.sv
// Shared constants and types for the Gauss-Seidel update datapath.
// Default widths, the 1/20 reciprocal and stencil coefficients live here.
package gsim_pkg;
  localparam int DEF_BIT_WIDTH = 32;
  localparam int DEF_FRAC      = 16;
  localparam int DEF_B_WIDTH   = 16;
  localparam int N_X           = 16;
  localparam int IDX_W         = $clog2(N_X);
  localparam int INV20_Q16     = 3277;
  localparam int INV_SH        = 16;
  localparam int C13           = 13;
  localparam int C6            = 6;
  localparam int C1            = 1;

  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/gsim_update_pe_if.sv
// Neighbour/b input bundle and result bundle of the update element.
// master drives the stencil inputs, slave is the update element.
interface gsim_update_pe_if
  import gsim_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH
) ();
  logic                        in_valid;
  logic signed [B_WIDTH-1:0]   b_in;
  logic signed [BIT_WIDTH-1:0] x1;
  logic signed [BIT_WIDTH-1:0] x2;
  logic signed [BIT_WIDTH-1:0] x3;
  logic signed [BIT_WIDTH-1:0] x4;
  logic signed [BIT_WIDTH-1:0] x5;
  logic signed [BIT_WIDTH-1:0] x6;
  logic                        out_valid;
  logic signed [BIT_WIDTH-1:0] x_out;
  idx_t                        out_idx;

  modport master (
    output in_valid, b_in,
    output x1, x2, x3, x4, x5, x6,
    input  out_valid, x_out, out_idx
  );

  modport slave (
    input  in_valid, b_in,
    input  x1, x2, x3, x4, x5, x6,
    output out_valid, x_out, out_idx
  );
endinterface

// File: rtl/gsim_sat.sv
// Combinational signed saturation from IN_W bits down to OUT_W bits.
// Clamps to the most positive / most negative OUT_W value on overflow.
module gsim_sat #(
  parameter int IN_W  = 52,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  i_d,
  output logic signed [OUT_W-1:0] o_q
);
  logic [IN_W-OUT_W:0] w_hi;
  logic                w_ovf;

  // In range iff all bits above the result sign agree with it
  assign w_hi  = i_d[IN_W-1:OUT_W-1];
  assign w_ovf = !((&w_hi) || !(|w_hi));

  always_comb begin
    o_q = i_d[OUT_W-1:0];
    if (w_ovf) begin
      o_q = i_d[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                        : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/gsim_update_pe.sv
// Gauss-Seidel update element: x = (b + 13s1 - 6s2 + s3) / 20.
// Three-stage pipeline, full throughput, tags each result with its index.
module gsim_update_pe
  import gsim_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int FRAC      = DEF_FRAC,
  parameter int B_WIDTH   = DEF_B_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  input logic             clear,
  gsim_update_pe_if.slave bus
);
  localparam int SW    = BIT_WIDTH + 1;
  localparam int ACC_W = BIT_WIDTH + 7;
  localparam int PW    = ACC_W + 13;
  localparam int RND   = 1 << (INV_SH - 1);

  function automatic logic signed [ACC_W-1:0] f_shadd(
    input logic signed [ACC_W-1:0] s,
    input logic [3:0]              c
  );
    f_shadd = '0;
    for (int k = 0; k < 4; k++) begin
      if (c[k]) f_shadd = f_shadd + (s <<< k);
    end
  endfunction

  logic                        r_v1;
  logic signed [SW-1:0]        r_s12;
  logic signed [SW-1:0]        r_s34;
  logic signed [SW-1:0]        r_s56;
  logic signed [ACC_W-1:0]     r_bq;
  logic                        r_v2;
  logic signed [ACC_W-1:0]     r_acc;
  logic                        r_ov;
  logic signed [BIT_WIDTH-1:0] r_xo;
  idx_t                        r_idx;

  logic signed [SW-1:0]        w_s12;
  logic signed [SW-1:0]        w_s34;
  logic signed [SW-1:0]        w_s56;
  logic signed [ACC_W-1:0]     w_bq;
  logic signed [ACC_W-1:0]     w_acc;
  logic signed [PW-1:0]        w_p;
  logic signed [PW-1:0]        w_r;
  logic signed [BIT_WIDTH-1:0] w_sat;

  assign w_s12 = SW'(bus.x1) + SW'(bus.x2);
  assign w_s34 = SW'(bus.x3) + SW'(bus.x4);
  assign w_s56 = SW'(bus.x5) + SW'(bus.x6);
  assign w_bq  = ACC_W'(bus.b_in) <<< FRAC;

  assign w_acc = r_bq
               + f_shadd(ACC_W'(r_s12), 4'(C13))
               - f_shadd(ACC_W'(r_s34), 4'(C6))
               + f_shadd(ACC_W'(r_s56), 4'(C1));

  // Divide by 20 as a Q16 reciprocal multiply, round half up
  assign w_p = PW'(r_acc) * PW'(INV20_Q16);
  assign w_r = (w_p + PW'(RND)) >>> INV_SH;

  gsim_sat #(
    .IN_W  (PW),
    .OUT_W (BIT_WIDTH)
  ) u_sat (
    .i_d (w_r),
    .o_q (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_s12 <= '0;
      r_s34 <= '0;
      r_s56 <= '0;
      r_bq  <= '0;
      r_v2  <= 1'b0;
      r_acc <= '0;
      r_ov  <= 1'b0;
      r_xo  <= '0;
      r_idx <= '0;
    end else begin
      r_v1 <= bus.in_valid & ~clear;
      r_v2 <= r_v1 & ~clear;
      r_ov <= r_v2 & ~clear;
      if (bus.in_valid) begin
        r_s12 <= w_s12;
        r_s34 <= w_s34;
        r_s56 <= w_s56;
        r_bq  <= w_bq;
      end
      if (r_v1) r_acc <= w_acc;
      if (r_v2 && !clear) r_xo <= w_sat;
      if (clear) r_idx <= '0;
      else if (r_ov) r_idx <= idx_t'(r_idx + 1'b1);
    end
  end

  assign bus.out_valid = r_ov;
  assign bus.x_out     = r_xo;
  assign bus.out_idx   = r_idx;
endmodule

// File: tb/tb_gsim_update_pe.sv
// Self-checking bench for gsim_update_pe: vector table plus scoreboard.
// Corner sequences cover clear, mid-stream reset and index wrap.
module tb_gsim_update_pe;
  import gsim_pkg::*;

  typedef logic [31:0] xv_t [6];
  typedef struct {
    int          b;
    xv_t         x;
    logic [31:0] ex;
  } vec_t;
  typedef struct {
    logic [31:0] x;
    logic [3:0]  idx;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;

  int         n_chk   = 0;
  int         n_pass  = 0;
  logic [3:0] exp_idx = '0;
  exp_t       q[$];
  vec_t       tbl[5];

  always #5 clk = ~clk;

  gsim_update_pe_if bus ();

  gsim_update_pe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  function automatic logic [31:0] model(input int b, input xv_t x);
    longint acc;
    longint r;
    acc = longint'(b) * 65536
        + 13 * (longint'($signed(x[0])) + longint'($signed(x[1])))
        - 6  * (longint'($signed(x[2])) + longint'($signed(x[3])))
        +      (longint'($signed(x[4])) + longint'($signed(x[5])));
    r = (acc * 3277 + 32768) >>> 16;
    if (r > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (r < -64'sd2147483648) return 32'h8000_0000;
    return r[31:0];
  endfunction

  task automatic drive(input int b, input xv_t x, input logic v,
                       input logic push, input logic [31:0] ex);
    exp_t e;
    bus.in_valid = v;
    bus.b_in = 16'(b);
    bus.x1 = x[0];
    bus.x2 = x[1];
    bus.x3 = x[2];
    bus.x4 = x[3];
    bus.x5 = x[4];
    bus.x6 = x[5];
    if (v && push) begin
      e.x = ex;
      e.idx = exp_idx;
      q.push_back(e);
      exp_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    xv_t z;
    foreach (z[k]) z[k] = '0;
    drive(0, z, 1'b0, 1'b0, '0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check(name, 32'(q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious out_valid", 32'(bus.out_valid), 0);
      end else begin
        e = q.pop_front();
        check("x_out", bus.x_out, e.x);
        check("out_idx", 32'(bus.out_idx), 32'(e.idx));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    xv_t xr;
    int  br;

    tbl[0] = '{b: 0, x: '{32'h00010000, 32'h00010000, 32'h00010000,
                          32'h00010000, 32'h00010000, 32'h00010000},
               ex: 32'h0000CCD0};
    tbl[1] = '{b: 20, x: '{0, 0, 0, 0, 0, 0}, ex: 32'h00010004};
    tbl[2] = '{b: -20, x: '{0, 0, 0, 0, 0, 0}, ex: 32'hFFFEFFFC};
    tbl[3] = '{b: 0, x: '{32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0, 0},
               ex: 32'h7FFFFFFF};
    tbl[4] = '{b: 0, x: '{32'h80000000, 32'h80000000, 0, 0, 0, 0},
               ex: 32'h80000000};

    bus.in_valid = 1'b0;
    bus.b_in = '0;
    bus.x1 = '0;
    bus.x2 = '0;
    bus.x3 = '0;
    bus.x4 = '0;
    bus.x5 = '0;
    bus.x6 = '0;

    #1 rst_n = 1'b0;
    #1;
    check("rst out_valid", 32'(bus.out_valid), 0);
    check("rst x_out", bus.x_out, 0);
    check("rst out_idx", 32'(bus.out_idx), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) drive(tbl[i].b, tbl[i].x, 1'b1, 1'b1, tbl[i].ex);
    idle();
    drain("drain table");

    clear = 1'b1;
    idle();
    clear = 1'b0;
    exp_idx = '0;
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < 6; k++)
        xr[k] = (i % 3 == 0) ? $urandom : 32'($signed($urandom) >>> 10);
      br = int'(shortint'($urandom));
      drive(br, xr, 1'b1, 1'b1, model(br, xr));
    end
    idle();
    drain("drain burst");

    drive(tbl[0].b, tbl[0].x, 1'b1, 1'b0, '0);
    drive(tbl[1].b, tbl[1].x, 1'b1, 1'b0, '0);
    clear = 1'b1;
    drive(tbl[2].b, tbl[2].x, 1'b1, 1'b0, '0);
    clear = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("clear drop", 32'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;
    exp_idx = '0;
    drive(tbl[0].b, tbl[0].x, 1'b1, 1'b1, tbl[0].ex);
    idle();
    drain("drain after clear");

    drive(tbl[1].b, tbl[1].x, 1'b1, 1'b0, '0);
    drive(tbl[2].b, tbl[2].x, 1'b1, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 0);
    check("midrst x_out", bus.x_out, 0);
    check("midrst out_idx", 32'(bus.out_idx), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post-rst quiet", 32'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;
    exp_idx = '0;
    drive(tbl[1].b, tbl[1].x, 1'b1, 1'b1, tbl[1].ex);
    idle();
    drain("drain after reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
